// File: rtl/vga_timing_gen.sv
// 640x480 VGA timing source: pixel coordinates, syncs, display enable and line/frame strobes.
// Optional completed-frame counter is built only when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1
) (
  input  logic        vgaclk,
  input  logic        resetn,
  output logic        pix_en,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_ACT_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_LIM = 10'(V_ACTIVE);
  localparam logic [1:0] DIV_LAST  = 2'(CLK_DIV - 1);

  logic [1:0] div_cnt_q, div_cnt_d;
  logic       pix_tick;
  logic       pix_en_q;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  logic [9:0] x_q, y_q;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // With CLK_DIV=1 the divider sits at zero and every vgaclk is a pixel.
  assign pix_tick  = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = pix_tick ? 2'd0 : div_cnt_q + 2'd1;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = 10'd0;
        vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // Decode from the counters so every output describes the same pixel as x/y.
  always_comb begin
    hsync_d       = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
    vsync_d       = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
    active_d      = (hcnt_q < H_ACT_LIM) && (vcnt_q < V_ACT_LIM);
    line_start_d  = (hcnt_q == 10'd0);
    frame_start_d = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  end

  always_ff @(posedge vgaclk) begin
    if (!resetn) begin
      div_cnt_q     <= 2'd0;
      pix_en_q      <= 1'b0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_tick;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      if (pix_tick) begin
        x_q           <= hcnt_q;
        y_q           <= vcnt_q;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        active_q      <= active_d;
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_end;

  assign frame_end   = pix_tick && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  assign frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge vgaclk) begin
    if (!resetn) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 16'd0;
`endif

  assign pix_en      = pix_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus two reduced-timing instances (CLK_DIV 1 and 4)
// checked every cycle against an arithmetic pixel-index model; honours VGA_FRAME_CNT_EN.
module tb_vga_timing_gen;

  logic vgaclk;
  logic resetn;

  logic        defPix, defHs, defVs, defAct, defLs, defFs;
  logic [9:0]  defX, defY;
  logic [15:0] defFc;
  logic        s1Pix, s1Hs, s1Vs, s1Act, s1Ls, s1Fs;
  logic [9:0]  s1X, s1Y;
  logic [15:0] s1Fc;
  logic        s4Pix, s4Hs, s4Vs, s4Act, s4Ls, s4Fs;
  logic [9:0]  s4X, s4Y;
  logic [15:0] s4Fc;

  int checks = 0;
  int errors = 0;
  int eCnt = 0;
  logic [63:0] sbQ[$];

  int hsLow = 0, hsOut = 0, actCnt = 0, lsA = 0, lsB = 0;
  int vsLow = 0, fsA1 = 0, fsB1 = 0, wrapSeen = 0, wrapBad = 0;
  int fsA4 = 0, fsB4 = 0, runLen = 0, runsSeen = 0, runBad = 0, pixCnt = 0;
  logic [9:0] s1PrevY = '0;
  logic s4PrevFs = 1'b0;

  localparam logic [63:0] RESET_BUNDLE = {22'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 16'd0};

  vga_timing_gen u_def (
    .vgaclk(vgaclk), .resetn(resetn), .pix_en(defPix), .x(defX), .y(defY),
    .hsync(defHs), .vsync(defVs), .active(defAct), .line_start(defLs),
    .frame_start(defFs), .frame_count(defFc)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(1)
  ) u_s1 (
    .vgaclk(vgaclk), .resetn(resetn), .pix_en(s1Pix), .x(s1X), .y(s1Y),
    .hsync(s1Hs), .vsync(s1Vs), .active(s1Act), .line_start(s1Ls),
    .frame_start(s1Fs), .frame_count(s1Fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(4)
  ) u_s4 (
    .vgaclk(vgaclk), .resetn(resetn), .pix_en(s4Pix), .x(s4X), .y(s4Y),
    .hsync(s4Hs), .vsync(s4Vs), .active(s4Act), .line_start(s4Ls),
    .frame_start(s4Fs), .frame_count(s4Fc)
  );

  initial begin
    vgaclk = 1'b0;
    forever #5 vgaclk = ~vgaclk;
  end

  // Expected outputs after e rising edges since reset release, from the pixel index alone.
  function automatic logic [63:0] model(input int e, input int d,
                                        input int ha, input int hfp, input int hs, input int hb,
                                        input int va, input int vfp, input int vs, input int vb);
    int ht, vt, m, p, xx, yy;
    logic hsy, vsy, act, ls, fs;
    logic [15:0] fc;
    ht = ha + hfp + hs + hb;
    vt = va + vfp + vs + vb;
    m  = e / d;
    if (m == 0) return RESET_BUNDLE;
    p   = m - 1;
    xx  = p % ht;
    yy  = (p / ht) % vt;
    hsy = !((xx >= ha + hfp) && (xx < ha + hfp + hs));
    vsy = !((yy >= va + vfp) && (yy < va + vfp + vs));
    act = (xx < ha) && (yy < va);
    ls  = (xx == 0);
    fs  = (xx == 0) && (yy == 0);
`ifdef VGA_FRAME_CNT_EN
    fc = 16'((m / (ht * vt)) % 65536);
`else
    fc = 16'd0;
`endif
    return {22'd0, (e % d == 0), 10'(xx), 10'(yy), hsy, vsy, act, ls, fs, fc};
  endfunction

  task automatic doCheck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, eCnt);
    end
  endtask

  task automatic checkOutput();
    logic [63:0] expBundle;
    string tags[3] = '{"sb_def", "sb_s1", "sb_s4"};
    logic [63:0] obs[3];
    obs[0] = {22'd0, defPix, defX, defY, defHs, defVs, defAct, defLs, defFs, defFc};
    obs[1] = {22'd0, s1Pix, s1X, s1Y, s1Hs, s1Vs, s1Act, s1Ls, s1Fs, s1Fc};
    obs[2] = {22'd0, s4Pix, s4X, s4Y, s4Hs, s4Vs, s4Act, s4Ls, s4Fs, s4Fc};
    for (int i = 0; i < 3; i++) begin
      if (sbQ.size() == 0) begin
        doCheck("sb_underflow", 64'd0, 64'd1);
      end else begin
        expBundle = sbQ.pop_front();
        doCheck(tags[i], obs[i], expBundle);
      end
    end
    if (eCnt > 0) begin
      if (eCnt <= 800) begin
        if (!defHs) begin
          hsLow++;
          if (defX < 10'd656 || defX > 10'd751) hsOut++;
        end
        if (defAct) actCnt++;
      end
      if (defLs) begin
        if (lsA == 0) lsA = eCnt;
        else if (lsB == 0) lsB = eCnt;
      end
      if (eCnt <= 375 && !s1Vs) vsLow++;
      if (s1Fs) begin
        if (fsA1 == 0) fsA1 = eCnt;
        else if (fsB1 == 0) fsB1 = eCnt;
        if (eCnt > 1) begin
          wrapSeen++;
          if (s1PrevY != 10'd14) wrapBad++;
        end
      end
      if (s4Fs && !s4PrevFs) begin
        if (fsA4 == 0) fsA4 = eCnt;
        else if (fsB4 == 0) fsB4 = eCnt;
      end
      if (s4Ls) runLen++;
      else if (runLen > 0) begin
        runsSeen++;
        if (runLen != 4) runBad++;
        runLen = 0;
      end
      if (eCnt <= 1500 && s4Pix) pixCnt++;
    end
    s1PrevY  = s1Y;
    s4PrevFs = s4Fs;
  endtask

  // Drives resetn for n edges, queueing the model's prediction for each edge before checking.
  task automatic applyStimulus(input logic rstn, input int n);
    for (int i = 0; i < n; i++) begin
      resetn = rstn;
      @(posedge vgaclk);
      eCnt = rstn ? eCnt + 1 : 0;
      sbQ.push_back(model(eCnt, 1, 640, 16, 96, 48, 480, 10, 2, 33));
      sbQ.push_back(model(eCnt, 1, 16, 2, 4, 3, 8, 2, 2, 3));
      sbQ.push_back(model(eCnt, 4, 16, 2, 4, 3, 8, 2, 2, 3));
      #1;
      checkOutput();
    end
  endtask

  initial begin
    resetn = 1'b0;
    $display("[TB] reset and first pixel");
    applyStimulus(1'b0, 5);
    doCheck("reset_state", {22'd0, defPix, defX, defY, defHs, defVs, defAct, defLs, defFs, defFc},
            RESET_BUNDLE);
    applyStimulus(1'b1, 1);
    doCheck("first_pixel", {defX, defY, defAct, defLs, defFs}, {10'd0, 10'd0, 3'b111});

    $display("[TB] lines and frames");
    applyStimulus(1'b1, 4499);
    doCheck("hsync_low_cycles", hsLow, 96);
    doCheck("hsync_low_outside", hsOut, 0);
    doCheck("active_cycles_line0", actCnt, 640);
    doCheck("line_start_period", lsB - lsA, 800);
    doCheck("s1_vsync_low_cycles", vsLow, 50);
    doCheck("s1_frame_period", fsB1 - fsA1, 375);
    doCheck("s1_wrap_count", wrapSeen, 11);
    doCheck("s1_wrap_prev_y", wrapBad, 0);
    doCheck("s4_frame_period", fsB4 - fsA4, 1500);
    doCheck("s4_line_start_runs", runsSeen, 45);
    doCheck("s4_line_start_width", runBad, 0);
    doCheck("s4_pix_en_rate", pixCnt, 375);
`ifdef VGA_FRAME_CNT_EN
    doCheck("s4_frame_count", s4Fc, 16'd3);
    doCheck("s1_frame_count", s1Fc, 16'd12);
`else
    doCheck("s4_frame_count", s4Fc, 16'd0);
    doCheck("s1_frame_count", s1Fc, 16'd0);
`endif

    $display("[TB] mid-frame reset");
    applyStimulus(1'b1, 201);
    doCheck("pre_reset_pos", {defX, defY}, {10'd700, 10'd5});
    applyStimulus(1'b0, 1);
    doCheck("mid_reset_def", {22'd0, defPix, defX, defY, defHs, defVs, defAct, defLs, defFs, defFc},
            RESET_BUNDLE);
    doCheck("mid_reset_s4", {22'd0, s4Pix, s4X, s4Y, s4Hs, s4Vs, s4Act, s4Ls, s4Fs, s4Fc},
            RESET_BUNDLE);
    applyStimulus(1'b1, 1);
    doCheck("restart_pixel", {defX, defY, defAct, defLs, defFs}, {10'd0, 10'd0, 3'b111});
    applyStimulus(1'b1, 1600);
    doCheck("scoreboard_drained", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
